// File: rtl/img_sequencer_pkg.sv
// Shared types and helpers for the image capture/readout sequencer.
package img_sequencer_pkg;

  typedef enum logic [2:0] {
    Idle,
    CapIssue,
    CapWait,
    RdIssue,
    RdWait
  } seq_state_t;

  typedef enum logic [1:0] {
    ImgSeq_Err_None      = 2'd0,
    ImgSeq_Err_NoImage   = 2'd1,
    ImgSeq_Err_WordCount = 2'd2,
    ImgSeq_Err_Timeout   = 2'd3
  } seq_err_t;

  // Bits needed to hold the value n itself (counters that load n and count down to 0).
  function automatic int RegWidth(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/img_sequencer_if.sv
// Host request, controller command and status signals of the image sequencer.
interface img_sequencer_if
  import img_sequencer_pkg::*;
#(
  parameter int ImgWordCount = 4096 * 4096
);
  localparam int WcWidth = RegWidth(ImgWordCount);

  logic               req_capture;
  logic               req_readout;
  logic               req_skipCount;
  logic               req_thumb;
  logic               ic_capture;
  logic               ic_readout;
  logic               ic_ramBlock;
  logic               ic_skipCount;
  logic               ic_thumb;
  logic               ic_captureDone;
  logic [WcWidth-1:0] ic_captureWordCount;
  logic               ic_readoutXfer;
  logic               stat_busy;
  logic [1:0]         stat_valid;
  logic               stat_newest;
  logic               stat_captureOk;
  logic               stat_readoutDone;
  logic [1:0]         stat_err;

  modport master (
    input  req_capture, req_readout, req_skipCount, req_thumb,
    input  ic_captureDone, ic_captureWordCount, ic_readoutXfer,
    output ic_capture, ic_readout, ic_ramBlock, ic_skipCount, ic_thumb,
    output stat_busy, stat_valid, stat_newest, stat_captureOk, stat_readoutDone, stat_err
  );

  modport slave (
    output req_capture, req_readout, req_skipCount, req_thumb,
    output ic_captureDone, ic_captureWordCount, ic_readoutXfer,
    input  ic_capture, ic_readout, ic_ramBlock, ic_skipCount, ic_thumb,
    input  stat_busy, stat_valid, stat_newest, stat_captureOk, stat_readoutDone, stat_err
  );

endinterface

// File: rtl/img_sequencer_watchdog.sv
// Stall watchdog: reloads on clr, counts down while enabled, flags expiry at zero.
module img_sequencer_watchdog
  import img_sequencer_pkg::*;
#(
  parameter int TimeoutCycles = 48_000_000
) (
  input  logic clk,
  input  logic rst_,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);
  localparam int Width = RegWidth(TimeoutCycles);
  // Loading one less makes expiry land on the TimeoutCycles-th enabled cycle.
  localparam logic [Width-1:0] LoadValue = Width'(TimeoutCycles - 1);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= LoadValue;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/img_sequencer.sv
// Serialises host capture/readout requests onto the controller command port with double-buffered RAM blocks.
module img_sequencer
  import img_sequencer_pkg::*;
#(
  parameter int ImgWordCount  = 4096 * 4096,
  parameter int TimeoutCycles = 48_000_000
) (
  input logic             clk,
  input logic             rst_,
  img_sequencer_if.master bus
);
  localparam int WcWidth = RegWidth(ImgWordCount);
  localparam logic [WcWidth-1:0] WordTarget = WcWidth'(ImgWordCount);

  seq_state_t       r_state, w_nextState;
  seq_err_t         r_err;
  logic             r_pendCap, r_pendRd, r_doneSample;
  logic             r_icCapture, r_icReadout;
  logic             r_ramBlock, r_skipCount, r_thumb, r_busy, r_newest;
  logic [1:0]       r_valid;
  logic             r_captureOk, r_readoutDone;
  logic [WcWidth-1:0] r_rdCount;
  logic             w_doneEdge, w_grantRd, w_grantCap, w_noImage;
  logic             w_issueCap, w_issueRd, w_capFinish, w_rdFinish, w_timeout;
  logic             w_wdClr, w_wdEn, w_wdExpired;

  assign w_doneEdge = bus.ic_captureDone ^ r_doneSample;

  img_sequencer_watchdog #(.TimeoutCycles(TimeoutCycles)) u_watchdog (
    .clk       (clk),
    .rst_      (rst_),
    .i_clr     (w_wdClr),
    .i_en      (w_wdEn),
    .o_expired (w_wdExpired)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state   <= Idle;
      r_pendCap <= 1'b0;
      r_pendRd  <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_pendCap <= w_grantCap ? 1'b0 : (r_pendCap | bus.req_capture);
      r_pendRd  <= w_grantRd  ? 1'b0 : (r_pendRd  | bus.req_readout);
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_grantRd   = 1'b0;
    w_grantCap  = 1'b0;
    w_noImage   = 1'b0;
    w_issueCap  = 1'b0;
    w_issueRd   = 1'b0;
    w_capFinish = 1'b0;
    w_rdFinish  = 1'b0;
    w_timeout   = 1'b0;
    w_wdClr     = 1'b0;
    w_wdEn      = 1'b0;
    unique case (r_state)
      Idle: begin
        // Readout wins a tie so the newest image is read before it can be overwritten.
        if (r_pendRd) begin
          w_grantRd = 1'b1;
          if (r_valid == 2'b00) w_noImage = 1'b1;
          else                  w_nextState = RdIssue;
        end else if (r_pendCap) begin
          w_grantCap  = 1'b1;
          w_nextState = CapIssue;
        end
      end
      CapIssue: begin
        w_issueCap  = 1'b1;
        w_wdClr     = 1'b1;
        w_nextState = CapWait;
      end
      CapWait: begin
        w_wdEn = 1'b1;
        if (w_doneEdge) begin
          w_capFinish = 1'b1;
          w_nextState = Idle;
        end else if (w_wdExpired) begin
          w_timeout   = 1'b1;
          w_nextState = Idle;
        end
      end
      RdIssue: begin
        w_issueRd   = 1'b1;
        w_wdClr     = 1'b1;
        w_nextState = RdWait;
      end
      RdWait: begin
        w_wdEn = 1'b1;
        if (bus.ic_readoutXfer) begin
          w_wdClr = 1'b1;
          if (r_rdCount == WcWidth'(1)) begin
            w_rdFinish  = 1'b1;
            w_nextState = Idle;
          end
        end else if (w_wdExpired) begin
          w_timeout   = 1'b1;
          w_nextState = Idle;
        end
      end
      default: w_nextState = Idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_ramBlock    <= 1'b0;
      r_skipCount   <= 1'b0;
      r_thumb       <= 1'b0;
      r_busy        <= 1'b0;
      r_valid       <= 2'b00;
      r_newest      <= 1'b0;
      r_captureOk   <= 1'b0;
      r_readoutDone <= 1'b0;
      r_err         <= ImgSeq_Err_None;
      r_rdCount     <= '0;
    end else begin
      r_captureOk   <= 1'b0;
      r_readoutDone <= 1'b0;
      if (w_grantRd || w_grantCap) r_err <= w_noImage ? ImgSeq_Err_NoImage : ImgSeq_Err_None;
      if (w_grantRd && !w_noImage) begin
        r_ramBlock <= r_newest;
        r_thumb    <= bus.req_thumb;
        r_busy     <= 1'b1;
      end
      // The target block is invalidated up front: a failed capture must never leave a stale image marked valid.
      if (w_grantCap) begin
        r_ramBlock          <= ~r_newest;
        r_skipCount         <= bus.req_skipCount;
        r_valid[~r_newest]  <= 1'b0;
        r_busy              <= 1'b1;
      end
      if (w_issueRd) begin
        r_rdCount <= WordTarget;
      end else if ((r_state == RdWait) && bus.ic_readoutXfer && (r_rdCount != '0)) begin
        r_rdCount <= r_rdCount - 1'b1;
      end
      if (w_capFinish) begin
        r_busy <= 1'b0;
        if (bus.ic_captureWordCount == WordTarget) begin
          r_valid[r_ramBlock] <= 1'b1;
          r_newest            <= r_ramBlock;
          r_captureOk         <= 1'b1;
        end else begin
          r_err <= ImgSeq_Err_WordCount;
        end
      end
      if (w_rdFinish) begin
        r_busy        <= 1'b0;
        r_readoutDone <= 1'b1;
      end
      if (w_timeout) begin
        r_busy <= 1'b0;
        r_err  <= ImgSeq_Err_Timeout;
      end
    end
  end

  // Command toggles and the done sampler deliberately ignore reset so reset never fakes a command or a completion.
  always_ff @(posedge clk) begin
    r_doneSample <= bus.ic_captureDone;
    if (rst_ && w_issueCap) r_icCapture <= ~r_icCapture;
    if (rst_ && w_issueRd)  r_icReadout <= ~r_icReadout;
  end

  assign bus.ic_capture       = r_icCapture;
  assign bus.ic_readout       = r_icReadout;
  assign bus.ic_ramBlock      = r_ramBlock;
  assign bus.ic_skipCount     = r_skipCount;
  assign bus.ic_thumb         = r_thumb;
  assign bus.stat_busy        = r_busy;
  assign bus.stat_valid       = r_valid;
  assign bus.stat_newest      = r_newest;
  assign bus.stat_captureOk   = r_captureOk;
  assign bus.stat_readoutDone = r_readoutDone;
  assign bus.stat_err         = r_err;

endmodule
